// File: rtl/mc_alu_pkg.sv
// Shared opcode and MDU state encodings for mc_alu and its iterative datapath.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    ALU_OR   = 4'd0,
    ALU_AND  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_IMM  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mc_alu_mdu_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply, restoring divide,
// operating on magnitudes with a sign fix-up on the result.
module mdu_iter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc, q, m, a_keep, acc_nx, q_nx;
  logic             div_mode, div0, neg_q, neg_r;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_div    = (op == MD_DIV)  || (op == MD_DIVU);
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      a_keep   <= '0;
      div_mode <= 1'b0;
      div0     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q        <= is_div ? a_mag : b_mag;
      m        <= is_div ? b_mag : a_mag;
      a_keep   <= a;
      div_mode <= is_div;
      div0     <= is_div && (b == '0);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
    end else if (step) begin
      acc <= acc_nx;
      q   <= q_nx;
    end
  end

  // One iteration; the accumulator stays below the divisor so diff[WIDTH] is the borrow.
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted = {acc, q[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    acc_nx  = acc;
    q_nx    = q;
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_nx, q_nx} = {sum, q[WIDTH-1:1]};
    end
  end

  assign prod     = {acc_nx, q_nx};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    if (!div_mode) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div0) begin
      hi_res = a_keep;
      lo_res = '1;
    end else begin
      hi_res = neg_r ? -acc_nx : acc_nx;
      lo_res = neg_q ? -q_nx : q_nx;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Combinational ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_op_i,
  input  logic [2:0]       md_op_i,
  input  logic             start_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] ao_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  mdu_state_e        state, state_nx;
  logic [SHW-1:0]    cnt;
  logic [WIDTH-1:0]  hi, lo, hi_res, lo_res;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic              start_ok, md_go, last_step;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    ao_o = '0;
    case (alu_op_i)
      ALU_OR:   ao_o = a_i | b_i;
      ALU_AND:  ao_o = a_i & b_i;
      ALU_ADD:  ao_o = a_i + b_i;
      ALU_SUB:  ao_o = a_i - b_i;
      ALU_IMM:  ao_o = b_i;
      ALU_XOR:  ao_o = a_i ^ b_i;
      ALU_NOR:  ao_o = ~(a_i | b_i);
      ALU_SLL:  ao_o = b_i << a_i[SHW-1:0];
      ALU_SRL:  ao_o = b_i >> a_i[SHW-1:0];
      ALU_SRA:  ao_o = b_s >>> a_i[SHW-1:0];
      ALU_SLT:  ao_o = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: ao_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default:  ao_o = '0;
    endcase
  end

  // flush_i in IDLE blocks a simultaneous start; MTHI/MTLO never leave IDLE.
  assign start_ok  = (state == S_IDLE) && start_i && !flush_i;
  assign md_go     = start_ok && ((md_op_i == MD_MULT) || (md_op_i == MD_MULTU) ||
                                  (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU));
  assign last_step = (state == S_RUN) && !flush_i && (cnt == '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (md_go) state_nx = S_RUN;
      S_RUN:   if (flush_i) state_nx = S_IDLE;
               else if (cnt == '0) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      if (md_go) cnt <= SHW'(WIDTH - 1);
      else if ((state == S_RUN) && (cnt != '0)) cnt <= cnt - 1'b1;
      // The final iteration's result is committed on the same edge that enters FIN.
      if (last_step) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (start_ok && (md_op_i == MD_MTHI)) begin
        hi <= a_i;
      end else if (start_ok && (md_op_i == MD_MTLO)) begin
        lo <= a_i;
      end
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (md_go),
    .step    (state == S_RUN),
    .op      (md_op_i),
    .a       (a_i),
    .b       (b_i),
    .hi_res  (hi_res),
    .lo_res  (lo_res)
  );

  assign hi_o   = hi;
  assign lo_o   = lo;
  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_FIN);

endmodule

// File: tb/tb_mc_alu.sv
// Directed-vector bench for mc_alu at WIDTH=32.
module tb_mc_alu;
  import mc_alu_pkg::*;

  logic        clk, reset_n, start_i, flush_i, busy_o, done_o;
  logic [31:0] a_i, b_i, ao_o, hi_o, lo_o;
  logic [3:0]  alu_op_i;
  logic [2:0]  md_op_i;
  int checks = 0;
  int errors = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .a_i(a_i), .b_i(b_i), .alu_op_i(alu_op_i),
    .md_op_i(md_op_i), .start_i(start_i), .flush_i(flush_i), .ao_o(ao_o),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    alu_op_i = op; a_i = a; b_i = b;
    #1 check_eq(tag, ao_o, exp);
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    md_op_i = op; a_i = val; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; md_op_i = MD_NONE;
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
  endtask

  // inj_kind: 0 none, 1 extra MULT start, 2 MTLO start, 3 flush (all at cycle inj_at)
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at, input int inj_kind,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_busy, input int exp_done_at);
    int busy_cnt, done_cnt, done_at;
    logic [31:0] hi_s, lo_s;
    busy_cnt = 0; done_cnt = 0; done_at = 0; hi_s = '0; lo_s = '0;
    @(negedge clk);
    a_i = a; b_i = b; md_op_i = op; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; md_op_i = MD_NONE;
    for (int n = 1; n <= 40; n++) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++; done_at = n; hi_s = hi_o; lo_s = lo_o;
      end
      if (n == inj_at) begin
        case (inj_kind)
          1: begin start_i = 1'b1; md_op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9; end
          2: begin start_i = 1'b1; md_op_i = MD_MTLO; a_i = 32'h5555; end
          3: flush_i = 1'b1;
          default: ;
        endcase
      end else if (n == inj_at + 1) begin
        start_i = 1'b0; flush_i = 1'b0; md_op_i = MD_NONE;
      end
      @(negedge clk);
    end
    check_eq({tag, "_busycyc"}, busy_cnt, exp_busy);
    check_eq({tag, "_donecnt"}, done_cnt, (exp_done_at != 0) ? 1 : 0);
    check_eq({tag, "_doneat"}, done_at, exp_done_at);
    if (exp_done_at != 0) begin
      check_eq({tag, "_hi_at_done"}, hi_s, exp_hi);
      check_eq({tag, "_lo_at_done"}, lo_s, exp_lo);
    end
    check_eq({tag, "_hi"}, hi_o, exp_hi);
    check_eq({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    int dcnt;
    reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    a_i = '0; b_i = '0; alu_op_i = ALU_OR; md_op_i = MD_NONE;
    #3;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_hi", hi_o, 0);
    check_eq("rst_lo", lo_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    alu("add_ovf", ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    check_eq("add_busy", busy_o, 0);
    alu("sra",  ALU_SRA,  32'd4, 32'h80000000, 32'hF8000000);
    alu("srl",  ALU_SRL,  32'd4, 32'h80000000, 32'h08000000);
    alu("sll",  ALU_SLL,  32'd33, 32'h1, 32'h2);
    alu("sub",  ALU_SUB,  32'd3, 32'd5, 32'hFFFFFFFE);
    alu("slt",  ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd1);
    alu("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu("imm",  ALU_IMM,  32'h1234, 32'hCAFE, 32'hCAFE);
    alu("nor",  ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h0000F0F);
    alu("xor",  ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0);
    alu("unk",  4'hF,     32'h1, 32'h2, 32'h0);

    run_md("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd5, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 33);
    run_md("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, 33, 33);
    run_md("divu",      MD_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 33, 33);
    run_md("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33);
    run_md("divu_0",    MD_DIVU,  32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFFFFFF, 33, 33);
    run_md("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 32'h80000000, 33, 33);

    mt("mthi", MD_MTHI, 32'h1234);
    check_eq("mthi_val", hi_o, 32'h1234);
    run_md("mult_after_mthi", MD_MULT, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, 33, 33);
    run_md("start_ign", MD_MULT, 32'd2, 32'd3, 10, 1, 32'd0, 32'd6, 33, 33);
    run_md("mtlo_busy", MD_MULT, 32'd7, 32'd6, 10, 2, 32'd0, 32'd42, 33, 33);

    mt("mthi_aa", MD_MTHI, 32'hAA);
    mt("mtlo_bb", MD_MTLO, 32'hBB);
    run_md("flush_run", MD_DIV, 32'd100, 32'd7, 5, 3, 32'hAA, 32'hBB, 5, 0);

    @(negedge clk);
    a_i = 32'd3; b_i = 32'd4; md_op_i = MD_MULTU; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0; md_op_i = MD_NONE;
    check_eq("flush_idle_busy", busy_o, 0);
    check_eq("flush_idle_lo", lo_o, 32'hBB);

    @(negedge clk);
    a_i = 32'd3; b_i = 32'd4; md_op_i = MD_MULTU; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; md_op_i = MD_NONE;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy_o, 0);
    check_eq("rst_mid_hi", hi_o, 0);
    check_eq("rst_mid_lo", lo_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) dcnt++;
    end
    check_eq("rst_mid_nodone", dcnt, 0);

    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; a_i = 32'd3; b_i = 32'd4; md_op_i = MD_MULTU; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; md_op_i = MD_NONE;
    check_eq("first_start_busy", busy_o, 1);
    repeat (40) @(negedge clk);
    check_eq("first_start_hi", hi_o, 0);
    check_eq("first_start_lo", lo_o, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
